// File: rtl/prog_sequencer.sv
// Program sequencer: loads the core PC, gates the core clock, acks completion.
// Steps through up to four program start addresses, one per start request.
module prog_sequencer #(
  parameter int          AW      = 10,
  parameter int          NPROG   = 3,
  parameter int          START0  = 0,
  parameter int          START1  = 128,
  parameter int          START2  = 256,
  parameter int          START3  = 384,
  parameter logic [15:0] TIMEOUT = 16'hFFFF
) (
  input  logic          CLK,
  input  logic          reset,
  input  logic          start,
  output logic          halt,
  input  logic          core_done,
  output logic          pc_load,
  output logic [AW-1:0] pc_start_addr,
  output logic          core_run,
  output logic [1:0]    prog_idx,
  output logic [15:0]   cycle_count,
  output logic          timeout
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  localparam logic [15:0] TLIM = TIMEOUT - 16'd1;
  localparam logic [1:0]  LAST = 2'(NPROG - 1);

  state_t      state;
  logic        start_q;
  logic        start_rise;
  logic        stop;
  logic [15:0] count_nxt;
  logic [1:0]  idx_nxt;

  assign start_rise = start & ~start_q;
  assign stop       = core_done | (cycle_count == TLIM);
  assign idx_nxt    = (prog_idx == LAST) ? 2'd0 : prog_idx + 2'd1;
  assign count_nxt  = (cycle_count == 16'hFFFF) ? cycle_count
                                                : cycle_count + 16'd1;

  always_comb begin
    pc_start_addr = AW'(START0);
    case (prog_idx)
      2'd0:    pc_start_addr = AW'(START0);
      2'd1:    pc_start_addr = AW'(START1);
      2'd2:    pc_start_addr = AW'(START2);
      default: pc_start_addr = AW'(START3);
    endcase
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state       <= IDLE;
      start_q     <= 1'b0;
      halt        <= 1'b0;
      pc_load     <= 1'b0;
      core_run    <= 1'b0;
      prog_idx    <= 2'd0;
      cycle_count <= 16'd0;
      timeout     <= 1'b0;
    end else begin
      start_q <= start;
      case (state)
        IDLE, DONE: begin
          if (start_rise) begin
            state       <= LOAD;
            pc_load     <= 1'b1;
            halt        <= 1'b0;
            cycle_count <= 16'd0;
            timeout     <= 1'b0;
          end
        end
        LOAD: begin
          state    <= RUN;
          pc_load  <= 1'b0;
          core_run <= 1'b1;
        end
        RUN: begin
          cycle_count <= count_nxt;
          // core_done beats a simultaneous timeout
          if (stop) begin
            state    <= DONE;
            core_run <= 1'b0;
            halt     <= 1'b1;
            timeout  <= ~core_done;
            prog_idx <= idx_nxt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: default instance plus a TIMEOUT=8 instance.
// Expected values are hand-derived from the cycle-level behaviour.
module tb_prog_sequencer;

  logic        CLK;
  logic        reset;
  logic        start_a, done_a, start_b, done_b;
  logic        halt_a, pc_load_a, core_run_a, timeout_a;
  logic        halt_b, pc_load_b, core_run_b, timeout_b;
  logic [9:0]  addr_a, addr_b;
  logic [1:0]  idx_a, idx_b;
  logic [15:0] cnt_a, cnt_b;

  int total = 0;
  int bad   = 0;
  int loads = 0;

  prog_sequencer u_a (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start_a),
    .halt         (halt_a),
    .core_done    (done_a),
    .pc_load      (pc_load_a),
    .pc_start_addr(addr_a),
    .core_run     (core_run_a),
    .prog_idx     (idx_a),
    .cycle_count  (cnt_a),
    .timeout      (timeout_a)
  );

  prog_sequencer #(.TIMEOUT(16'd8)) u_b (
    .CLK          (CLK),
    .reset        (reset),
    .start        (start_b),
    .halt         (halt_b),
    .core_done    (done_b),
    .pc_load      (pc_load_b),
    .pc_start_addr(addr_b),
    .core_run     (core_run_b),
    .prog_idx     (idx_b),
    .cycle_count  (cnt_b),
    .timeout      (timeout_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (pc_load_a) loads++;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic run_prog(input int addr, input int idx_after,
                          input int n_run, input int hold,
                          input int glitch_at);
    int l0;
    int ok;
    l0 = loads;
    ok = 1;
    start_a = 1'b1;
    step();
    chk("load_strobe", 32'(pc_load_a), 1);
    chk("load_addr", 32'(addr_a), 32'(addr));
    chk("load_halt", 32'(halt_a), 0);
    chk("load_run", 32'(core_run_a), 0);
    if (hold <= 1) start_a = 1'b0;
    for (int i = 1; i <= n_run; i++) begin
      step();
      if (!(core_run_a === 1'b1 && pc_load_a === 1'b0 && halt_a === 1'b0))
        ok = 0;
      if (i + 1 >= hold && hold > 1) start_a = 1'b0;
      if (i == glitch_at) start_a = 1'b1;
      if (i == glitch_at + 1) start_a = 1'b0;
      if (i == n_run) done_a = 1'b1;
    end
    if (hold > n_run + 1) start_a = 1'b1;
    chk("run_clean", 32'(ok), 1);
    step();
    done_a = 1'b0;
    chk("done_halt", 32'(halt_a), 1);
    chk("done_run", 32'(core_run_a), 0);
    chk("done_cnt", 32'(cnt_a), 32'(n_run));
    chk("done_idx", 32'(idx_a), 32'(idx_after));
    chk("done_tmo", 32'(timeout_a), 0);
    chk("one_load", 32'(loads - l0), 1);
  endtask

  initial begin
    int l0;
    int ok;
    reset   = 1'b1;
    start_a = 1'b0;
    done_a  = 1'b0;
    start_b = 1'b0;
    done_b  = 1'b0;
    step();
    step();
    chk("rst_halt", 32'(halt_a), 0);
    chk("rst_pcload", 32'(pc_load_a), 0);
    chk("rst_run", 32'(core_run_a), 0);
    chk("rst_idx", 32'(idx_a), 0);
    chk("rst_cnt", 32'(cnt_a), 0);
    chk("rst_tmo", 32'(timeout_a), 0);
    chk("rst_addr", 32'(addr_a), 0);
    reset = 1'b0;
    step();

    // core_done ignored while idle
    done_a = 1'b1;
    step();
    done_a = 1'b0;
    step();
    chk("idle_done_ign", 32'(halt_a), 0);

    run_prog(0, 1, 21, 1, 0);
    run_prog(128, 2, 5, 1, 3);
    run_prog(256, 0, 3, 1, 0);

    // start held high across DONE: only one LOAD
    run_prog(0, 1, 2, 5, 0);
    step();
    step();
    start_a = 1'b0;
    step();
    chk("held_halt", 32'(halt_a), 1);
    chk("held_pcload", 32'(pc_load_a), 0);

    // timeout instance: never assert core_done
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_load", 32'(pc_load_b), 1);
    ok = 1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (core_run_b !== 1'b1) ok = 0;
    end
    chk("b_run8", 32'(ok), 1);
    step();
    chk("b_tmo_run", 32'(core_run_b), 0);
    chk("b_tmo_halt", 32'(halt_b), 1);
    chk("b_tmo_flag", 32'(timeout_b), 1);
    chk("b_tmo_cnt", 32'(cnt_b), 8);
    chk("b_tmo_idx", 32'(idx_b), 1);
    step();
    chk("b_tmo_hold", 32'(timeout_b), 1);

    // tie: core_done in the 8th RUN cycle
    start_b = 1'b1;
    step();
    start_b = 1'b0;
    chk("b_tie_clr", 32'(timeout_b), 0);
    chk("b_tie_addr", 32'(addr_b), 128);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 8) done_b = 1'b1;
    end
    step();
    done_b = 1'b0;
    chk("b_tie_tmo", 32'(timeout_b), 0);
    chk("b_tie_halt", 32'(halt_b), 1);
    chk("b_tie_cnt", 32'(cnt_b), 8);

    // reset mid-RUN abandons program
    start_a = 1'b1;
    step();
    start_a = 1'b0;
    chk("p5_addr", 32'(addr_a), 128);
    for (int i = 1; i <= 5; i++) step();
    chk("p5_run", 32'(core_run_a), 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mid_rst_run", 32'(core_run_a), 0);
    chk("mid_rst_halt", 32'(halt_a), 0);
    chk("mid_rst_idx", 32'(idx_a), 0);
    chk("mid_rst_cnt", 32'(cnt_a), 0);
    step();
    done_a = 1'b1;
    step();
    done_a = 1'b0;
    step();
    chk("mid_rst_noack", 32'(halt_a), 0);

    // start held through reset release counts as a rising edge
    l0 = loads;
    start_a = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    chk("rst_rel_load", 32'(pc_load_a), 1);
    chk("rst_rel_addr", 32'(addr_a), 0);
    start_a = 1'b0;
    step();
    chk("rst_rel_run", 32'(core_run_a), 1);
    chk("rst_rel_once", 32'(loads - l0), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
